// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the 5-stage pipeline scheduler: op widths, load encodings,
// multi-cycle FSM states, hazard priority levels and the stage-control bundle.
package hazard_ctrl_pkg;

    localparam int OP_WIDTH   = 7;
    localparam int LOAD_WIDTH = 3;
    localparam int ALU_WIDTH  = 4;

    localparam logic [LOAD_WIDTH-1:0] LD_NONE = 3'd0;
    localparam logic [LOAD_WIDTH-1:0] LD_LB   = 3'd1;
    localparam logic [LOAD_WIDTH-1:0] LD_LH   = 3'd2;
    localparam logic [LOAD_WIDTH-1:0] LD_LW   = 3'd3;
    localparam logic [LOAD_WIDTH-1:0] LD_LBU  = 3'd4;
    localparam logic [LOAD_WIDTH-1:0] LD_LHU  = 3'd5;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

    // Winning hazard for the current cycle, highest priority last.
    typedef enum logic [2:0] {
        HZ_NONE,
        HZ_LOADUSE,
        HZ_MISPREDICT,
        HZ_MCWAIT,
        HZ_MEMWAIT,
        HZ_RESET
    } hz_level_t;

    typedef struct packed {
        logic f_stall;
        logic f_bubble;
        logic d_stall;
        logic d_bubble;
        logic e_stall;
        logic m_stall;
        logic m_bubble;
        logic w_bubble;
    } hz_ctrl_t;

    function automatic hz_ctrl_t hz_decode(input hz_level_t lvl);
        hz_ctrl_t c;
        c = '0;
        case (lvl)
            HZ_RESET: begin
                c.f_bubble = 1'b1;
                c.d_bubble = 1'b1;
                c.m_bubble = 1'b1;
                c.w_bubble = 1'b1;
            end
            HZ_MEMWAIT: begin
                c.f_stall  = 1'b1;
                c.d_stall  = 1'b1;
                c.e_stall  = 1'b1;
                c.m_stall  = 1'b1;
                c.w_bubble = 1'b1;
            end
            HZ_MCWAIT: begin
                c.f_stall  = 1'b1;
                c.d_stall  = 1'b1;
                c.e_stall  = 1'b1;
                c.m_bubble = 1'b1;
            end
            HZ_MISPREDICT: begin
                c.f_bubble = 1'b1;
                c.d_bubble = 1'b1;
            end
            // Bubble wins over stall in decode_reg, so the load result can retire.
            HZ_LOADUSE: begin
                c.f_stall  = 1'b1;
                c.d_stall  = 1'b1;
                c.d_bubble = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard inputs from the D/E/M stages and the stall/bubble controls returned to
// the inter-stage registers.
interface hazard_ctrl_if;

    logic [4:0]                              D_rs1_i;
    logic [4:0]                              D_rs2_i;
    logic                                    D_use_rs1_i;
    logic                                    D_use_rs2_i;
    logic [hazard_ctrl_pkg::LOAD_WIDTH-1:0]  DD_load_op_i;
    logic                                    DD_need_dstE_i;
    logic [4:0]                              DD_dstE_i;
    logic                                    E_mispredict_i;
    logic                                    E_mc_start_i;
    logic                                    E_mc_done_i;
    logic                                    M_mem_req_i;
    logic                                    M_mem_ready_i;

    logic F_stall_o;
    logic F_bubble_o;
    logic D_stall_o;
    logic D_bubble_o;
    logic E_stall_o;
    logic M_stall_o;
    logic M_bubble_o;
    logic W_bubble_o;

    modport master (
        output D_rs1_i, D_rs2_i, D_use_rs1_i, D_use_rs2_i,
        output DD_load_op_i, DD_need_dstE_i, DD_dstE_i,
        output E_mispredict_i, E_mc_start_i, E_mc_done_i,
        output M_mem_req_i, M_mem_ready_i,
        input  F_stall_o, F_bubble_o, D_stall_o, D_bubble_o,
        input  E_stall_o, M_stall_o, M_bubble_o, W_bubble_o
    );

    modport slave (
        input  D_rs1_i, D_rs2_i, D_use_rs1_i, D_use_rs2_i,
        input  DD_load_op_i, DD_need_dstE_i, DD_dstE_i,
        input  E_mispredict_i, E_mc_start_i, E_mc_done_i,
        input  M_mem_req_i, M_mem_ready_i,
        output F_stall_o, F_bubble_o, D_stall_o, D_bubble_o,
        output E_stall_o, M_stall_o, M_bubble_o, W_bubble_o
    );

endinterface

// File: rtl/hazard_perf_cnt.sv
// Stall-cycle and mispredict-flush performance counters; both wrap silently.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             i_stall_inc,
    input  logic             i_flush_inc,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (i_stall_inc) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (i_flush_inc) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline scheduler: prioritises memory wait, multi-cycle wait, mispredict and
// load-use hazards into same-cycle stage controls; tracks mul/div with a watchdog.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int MC_TIMEOUT = 64,
    parameter int TO_W       = 7
) (
    input  logic             clk_i,
    input  logic             rst_n,
    hazard_ctrl_if.slave     hz,
    output logic             mc_busy_o,
    output logic             mc_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    mc_state_t       r_state;
    logic [TO_W-1:0] r_wd;
    logic            r_err;
    logic            r_busy;

    logic            w_hit_rs1;
    logic            w_hit_rs2;
    logic            w_loaduse;
    logic            w_memwait;
    logic            w_mcwait;
    logic            w_mc_enter;
    logic [TO_W-1:0] w_wd_next;
    hz_level_t       w_level;
    hz_ctrl_t        w_ctl;

    assign w_hit_rs1 = hz.D_use_rs1_i && (hz.D_rs1_i == hz.DD_dstE_i);
    assign w_hit_rs2 = hz.D_use_rs2_i && (hz.D_rs2_i == hz.DD_dstE_i);
    assign w_loaduse = (hz.DD_load_op_i != LD_NONE) && hz.DD_need_dstE_i &&
                       (hz.DD_dstE_i != 5'd0) && (w_hit_rs1 || w_hit_rs2);

    assign w_memwait  = hz.M_mem_req_i && !hz.M_mem_ready_i;
    assign w_mc_enter = hz.E_mc_start_i && !hz.E_mc_done_i;
    assign w_mcwait   = (r_state == MC_BUSY) ? !hz.E_mc_done_i : w_mc_enter;

    // NOTE: default assigned first so every path drives w_level and no latch is inferred.
    always_comb begin
        w_level = HZ_NONE;
        if (!rst_n)                 w_level = HZ_RESET;
        else if (w_memwait)         w_level = HZ_MEMWAIT;
        else if (w_mcwait)          w_level = HZ_MCWAIT;
        else if (hz.E_mispredict_i) w_level = HZ_MISPREDICT;
        else if (w_loaduse)         w_level = HZ_LOADUSE;
    end

    assign w_ctl         = hz_decode(w_level);
    assign hz.F_stall_o  = w_ctl.f_stall;
    assign hz.F_bubble_o = w_ctl.f_bubble;
    assign hz.D_stall_o  = w_ctl.d_stall;
    assign hz.D_bubble_o = w_ctl.d_bubble;
    assign hz.E_stall_o  = w_ctl.e_stall;
    assign hz.M_stall_o  = w_ctl.m_stall;
    assign hz.M_bubble_o = w_ctl.m_bubble;
    assign hz.W_bubble_o = w_ctl.w_bubble;

    // Watchdog saturates so a hung op keeps the error asserted without wrapping.
    assign w_wd_next = (r_wd == TO_W'(MC_TIMEOUT)) ? r_wd : r_wd + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_state <= MC_IDLE;
            r_busy  <= 1'b0;
            r_wd    <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                MC_IDLE: begin
                    if (w_mc_enter && !w_memwait) begin
                        r_state <= MC_BUSY;
                        r_busy  <= 1'b1;
                        r_wd    <= '0;
                    end
                end
                MC_BUSY: begin
                    r_wd <= w_wd_next;
                    if (w_wd_next == TO_W'(MC_TIMEOUT)) r_err <= 1'b1;
                    // A memory wait freezes E, so the done result must be presented again.
                    if (hz.E_mc_done_i && !w_memwait) begin
                        r_state <= MC_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= MC_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mc_busy_o = r_busy;
    assign mc_err_o  = r_err;

    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .i_stall_inc (hz.F_stall_o),
        .i_flush_inc (w_level == HZ_MISPREDICT),
        .o_stall_cnt (stall_cnt_o),
        .o_flush_cnt (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scenarios plus a randomized run against a rule-level reference model
// of the pipeline scheduler (small counters and watchdog for quick corner cases).
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int CNT_W      = 4;
    localparam int MC_TIMEOUT = 8;
    localparam int TO_W       = 4;

    // Control vector order: F_stall F_bubble D_stall D_bubble E_stall M_stall M_bubble W_bubble
    localparam logic [7:0] CTL_NONE = 8'b0000_0000;
    localparam logic [7:0] CTL_RST  = 8'b0101_0011;
    localparam logic [7:0] CTL_MEM  = 8'b1010_1101;
    localparam logic [7:0] CTL_MC   = 8'b1010_1010;
    localparam logic [7:0] CTL_MISP = 8'b0101_0000;
    localparam logic [7:0] CTL_LU   = 8'b1011_0000;

    logic             clk_i = 1'b0;
    logic             rst_n;
    logic             mc_busy_o;
    logic             mc_err_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    hazard_ctrl_if hz();

    hazard_ctrl #(
        .CNT_W      (CNT_W),
        .MC_TIMEOUT (MC_TIMEOUT),
        .TO_W       (TO_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .hz          (hz),
        .mc_busy_o   (mc_busy_o),
        .mc_err_o    (mc_err_o),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] ctl();
        return {hz.F_stall_o, hz.F_bubble_o, hz.D_stall_o, hz.D_bubble_o,
                hz.E_stall_o, hz.M_stall_o, hz.M_bubble_o, hz.W_bubble_o};
    endfunction

    task automatic next();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_in();
        hz.D_rs1_i        = 5'd0;
        hz.D_rs2_i        = 5'd0;
        hz.D_use_rs1_i    = 1'b0;
        hz.D_use_rs2_i    = 1'b0;
        hz.DD_load_op_i   = LD_NONE;
        hz.DD_need_dstE_i = 1'b0;
        hz.DD_dstE_i      = 5'd0;
        hz.E_mispredict_i = 1'b0;
        hz.E_mc_start_i   = 1'b0;
        hz.E_mc_done_i    = 1'b0;
        hz.M_mem_req_i    = 1'b0;
        hz.M_mem_ready_i  = 1'b1;
    endtask

    task automatic lu_in(input logic [4:0] dst);
        hz.DD_load_op_i   = LD_LW;
        hz.DD_need_dstE_i = 1'b1;
        hz.DD_dstE_i      = dst;
        hz.D_rs2_i        = dst;
        hz.D_use_rs2_i    = 1'b1;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 1'b0;
        next();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_in();
        rst_n = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (ctl() !== CTL_RST) begin
            n_errors++; $display("FAIL reset_ctl got %b exp %b", ctl(), CTL_RST);
        end
        next();
        rst_n = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if ({mc_busy_o, mc_err_o, stall_cnt_o, flush_cnt_o} !== '0) begin
            n_errors++; $display("FAIL reset_state got busy=%b err=%b sc=%0d fc=%0d exp all 0",
                                 mc_busy_o, mc_err_o, stall_cnt_o, flush_cnt_o);
        end
        n_checks++;
        if (ctl() !== CTL_NONE) begin
            n_errors++; $display("FAIL reset_release_ctl got %b exp %b", ctl(), CTL_NONE);
        end
        next();
    endtask

    task automatic test_loaduse();
        do_reset();
        lu_in(5'd5);
        @(negedge clk_i);
        n_checks++;
        if (ctl() !== CTL_LU) begin
            n_errors++; $display("FAIL lu_ctl got %b exp %b", ctl(), CTL_LU);
        end
        next();
        idle_in();
        @(negedge clk_i);
        n_checks++;
        if (ctl() !== CTL_NONE) begin
            n_errors++; $display("FAIL lu_one_cycle got %b exp %b", ctl(), CTL_NONE);
        end
        n_checks++;
        if (stall_cnt_o !== 4'd1) begin
            n_errors++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt_o);
        end
        next();
        lu_in(5'd0);
        @(negedge clk_i);
        n_checks++;
        if (ctl() !== CTL_NONE) begin
            n_errors++; $display("FAIL lu_x0_ctl got %b exp %b", ctl(), CTL_NONE);
        end
        next();
        idle_in();
        @(negedge clk_i);
        n_checks++;
        if (stall_cnt_o !== 4'd1) begin
            n_errors++; $display("FAIL lu_x0_stall_cnt got %0d exp 1", stall_cnt_o);
        end
        next();
    endtask

    task automatic test_mispredict_loaduse();
        do_reset();
        lu_in(5'd7);
        hz.E_mispredict_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (ctl() !== CTL_MISP) begin
            n_errors++; $display("FAIL misp_lu_ctl got %b exp %b", ctl(), CTL_MISP);
        end
        next();
        idle_in();
        @(negedge clk_i);
        n_checks++;
        if (flush_cnt_o !== 4'd1 || stall_cnt_o !== 4'd0) begin
            n_errors++; $display("FAIL misp_lu_cnt got fc=%0d sc=%0d exp fc=1 sc=0",
                                 flush_cnt_o, stall_cnt_o);
        end
        next();
    endtask

    task automatic test_multicycle();
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            idle_in();
            hz.E_mc_start_i = (c == 0);
            hz.E_mc_done_i  = (c == 4);
            @(negedge clk_i);
            n_checks++;
            if (ctl() !== ((c < 4) ? CTL_MC : CTL_NONE)) begin
                n_errors++; $display("FAIL mc_ctl cycle %0d got %b exp %b", c, ctl(),
                                     (c < 4) ? CTL_MC : CTL_NONE);
            end
            if (c != 4) begin
                n_checks++;
                if (mc_busy_o !== (c >= 1 && c <= 3)) begin
                    n_errors++; $display("FAIL mc_busy cycle %0d got %b exp %b", c, mc_busy_o,
                                         (c >= 1 && c <= 3));
                end
            end
            if (c == 5) begin
                n_checks++;
                if (stall_cnt_o !== 4'd4) begin
                    n_errors++; $display("FAIL mc_stall_cnt got %0d exp 4", stall_cnt_o);
                end
            end
            next();
        end
    endtask

    task automatic test_memwait_busy();
        logic [7:0] exp_ctl;
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            idle_in();
            hz.E_mc_start_i   = (c == 0);
            hz.E_mc_done_i    = (c >= 2 && c <= 4);
            hz.E_mispredict_i = (c >= 2 && c <= 4);
            hz.M_mem_req_i    = (c >= 2 && c <= 4);
            hz.M_mem_ready_i  = !(c == 2 || c == 3);
            exp_ctl = (c <= 1) ? CTL_MC : (c <= 3) ? CTL_MEM : (c == 4) ? CTL_MISP : CTL_NONE;
            @(negedge clk_i);
            n_checks++;
            if (ctl() !== exp_ctl) begin
                n_errors++; $display("FAIL memwait_ctl cycle %0d got %b exp %b", c, ctl(), exp_ctl);
            end
            n_checks++;
            if (mc_busy_o !== (c >= 1 && c <= 4)) begin
                n_errors++; $display("FAIL memwait_busy cycle %0d got %b exp %b", c, mc_busy_o,
                                     (c >= 1 && c <= 4));
            end
            n_checks++;
            if (flush_cnt_o !== ((c == 5) ? 4'd1 : 4'd0)) begin
                n_errors++; $display("FAIL memwait_flush cycle %0d got %0d exp %0d", c,
                                     flush_cnt_o, (c == 5) ? 1 : 0);
            end
            next();
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            idle_in();
            hz.E_mc_start_i = (c == 0);
            @(negedge clk_i);
            if (c >= 8) begin
                n_checks++;
                if (mc_err_o !== (c >= 9)) begin
                    n_errors++; $display("FAIL wd_err cycle %0d got %b exp %b", c, mc_err_o, (c >= 9));
                end
            end
            if (c == 12) begin
                n_checks++;
                if (mc_busy_o !== 1'b1 || ctl() !== CTL_MC || stall_cnt_o !== 4'd12) begin
                    n_errors++; $display("FAIL wd_hold got busy=%b ctl=%b sc=%0d exp busy=1 ctl=%b sc=12",
                                         mc_busy_o, ctl(), stall_cnt_o, CTL_MC);
                end
            end
            next();
        end
        idle_in();
        rst_n = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (ctl() !== CTL_RST) begin
            n_errors++; $display("FAIL wd_reset_ctl got %b exp %b", ctl(), CTL_RST);
        end
        next();
        rst_n = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if ({mc_busy_o, mc_err_o, stall_cnt_o, flush_cnt_o} !== '0) begin
            n_errors++; $display("FAIL wd_reset_state got busy=%b err=%b sc=%0d fc=%0d exp all 0",
                                 mc_busy_o, mc_err_o, stall_cnt_o, flush_cnt_o);
        end
        next();
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            idle_in();
            hz.M_mem_req_i   = 1'b1;
            hz.M_mem_ready_i = 1'b0;
            @(negedge clk_i);
            if (i == 16) begin
                n_checks++;
                if (stall_cnt_o !== 4'd0) begin
                    n_errors++; $display("FAIL wrap_16 got %0d exp 0", stall_cnt_o);
                end
            end
            next();
        end
        idle_in();
        @(negedge clk_i);
        n_checks++;
        if (stall_cnt_o !== 4'd1) begin
            n_errors++; $display("FAIL wrap_17 got %0d exp 1", stall_cnt_o);
        end
        next();
    endtask

    // Reference model: busy flag, busy-cycle count, sticky error and modular counters.
    task automatic test_random();
        bit         m_busy = 0;
        bit         m_err  = 0;
        int         m_cycles = 0;
        int         m_sc = 0;
        int         m_fc = 0;
        bit         lu, mw, mcw;
        logic [7:0] exp_ctl;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst_n             = ($urandom_range(0, 63) != 0);
            hz.DD_load_op_i   = ($urandom_range(0, 2) == 0) ? LD_NONE : 3'($urandom_range(1, 5));
            hz.DD_need_dstE_i = 1'($urandom_range(0, 3) != 0);
            hz.DD_dstE_i      = 5'($urandom_range(0, 3));
            hz.D_rs1_i        = 5'($urandom_range(0, 3));
            hz.D_rs2_i        = 5'($urandom_range(0, 3));
            hz.D_use_rs1_i    = 1'($urandom_range(0, 1));
            hz.D_use_rs2_i    = 1'($urandom_range(0, 1));
            hz.E_mispredict_i = ($urandom_range(0, 6) == 0);
            hz.E_mc_start_i   = ($urandom_range(0, 6) == 0);
            hz.E_mc_done_i    = ($urandom_range(0, 9) < 3);
            hz.M_mem_req_i    = ($urandom_range(0, 9) < 3);
            hz.M_mem_ready_i  = 1'($urandom_range(0, 1));

            lu  = (hz.DD_load_op_i != 0) && hz.DD_need_dstE_i && (hz.DD_dstE_i != 0) &&
                  ((hz.D_use_rs1_i && hz.D_rs1_i == hz.DD_dstE_i) ||
                   (hz.D_use_rs2_i && hz.D_rs2_i == hz.DD_dstE_i));
            mw  = hz.M_mem_req_i && !hz.M_mem_ready_i;
            mcw = m_busy ? !hz.E_mc_done_i : (hz.E_mc_start_i && !hz.E_mc_done_i);
            exp_ctl = !rst_n ? CTL_RST : mw ? CTL_MEM : mcw ? CTL_MC :
                      hz.E_mispredict_i ? CTL_MISP : lu ? CTL_LU : CTL_NONE;

            @(negedge clk_i);
            n_checks++;
            if (ctl() !== exp_ctl) begin
                n_errors++; $display("FAIL rnd_ctl iter %0d got %b exp %b", n, ctl(), exp_ctl);
            end
            n_checks++;
            if (mc_busy_o !== m_busy || mc_err_o !== m_err) begin
                n_errors++; $display("FAIL rnd_fsm iter %0d got busy=%b err=%b exp busy=%b err=%b",
                                     n, mc_busy_o, mc_err_o, m_busy, m_err);
            end
            n_checks++;
            if (stall_cnt_o !== 4'(m_sc) || flush_cnt_o !== 4'(m_fc)) begin
                n_errors++; $display("FAIL rnd_cnt iter %0d got sc=%0d fc=%0d exp sc=%0d fc=%0d",
                                     n, stall_cnt_o, flush_cnt_o, m_sc, m_fc);
            end

            if (!rst_n) begin
                m_busy = 0; m_err = 0; m_cycles = 0; m_sc = 0; m_fc = 0;
            end else begin
                if (exp_ctl[7]) m_sc = (m_sc + 1) % 16;
                if (exp_ctl == CTL_MISP) m_fc = (m_fc + 1) % 16;
                if (m_busy) begin
                    if (m_cycles < MC_TIMEOUT) m_cycles++;
                    if (m_cycles == MC_TIMEOUT) m_err = 1;
                    if (hz.E_mc_done_i && !mw) m_busy = 0;
                end else if (hz.E_mc_start_i && !hz.E_mc_done_i && !mw) begin
                    m_busy   = 1;
                    m_cycles = 0;
                end
            end
            next();
        end
        rst_n = 1'b1;
        idle_in();
    endtask

    initial begin
        idle_in();
        rst_n = 1'b0;
        test_reset();
        test_loaduse();
        test_mispredict_loaduse();
        test_multicycle();
        test_memwait_busy();
        test_watchdog();
        test_counter_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
